// File: rtl/c2_pkg.sv
// c2_pkg: shared definitions for the client-2 requester of ram_arbiter.
// Holds the requester state encoding and the default RAM address/data widths,
// so the arbiter, the requester and the benches agree on them.
package c2_pkg;

  localparam int unsigned C2_ADDR_W = 4;
  localparam int unsigned C2_DATA_W = 8;

  // WAIT_RDY: arbiter not ready or ACK still high; IDLE: accepting a command;
  // REQ: REQUEST_C2 high, waiting for ACK; REL: REQUEST_C2 low, waiting for ACK to drop.
  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    IDLE     = 2'd1,
    REQ      = 2'd2,
    REL      = 2'd3
  } c2_state_e;

endpackage : c2_pkg

// File: rtl/c2_timeout_cnt.sv
// c2_timeout_cnt: request timeout down-counter.
// Loads CYCLES when a request is launched, counts down once per cycle while
// the request is outstanding, and flags the cycle in which it reaches zero.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load_i      reload the counter with CYCLES
//   dec_i       decrement (request outstanding this cycle)
//   expire_c    combinational: this decrement brings the count to zero
module c2_timeout_cnt #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_c
);

  localparam int unsigned CNT_BITS = $clog2(CYCLES + 1);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // Next count: reload wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_BITS'(CYCLES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire on the decrement that lands on zero, so the abort is seen
  // CYCLES cycles after the request rises.
  assign expire_c = dec_i && (cnt_q <= CNT_BITS'(1));

endmodule : c2_timeout_cnt

// File: rtl/c2_requester.sv
// c2_requester: client-2 initiator for ram_arbiter.
// Converts a valid/ready command stream into the REQUEST_C2/ACK_C2 four-phase
// handshake, one transaction outstanding, and returns a one-cycle response
// (read data or error) per accepted command.
// Optional feature: define C2_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYCLES cycles without ACK_C2 (error response).
// Ports:
//   CLOCK, RST          clock, synchronous active-high reset
//   RST_DONE            arbiter reset complete; no request while low
//   CMD_*               command stream (VALID/READY, RD_NOT_WRITE, ADDR, WRDATA)
//   RSP_*               response pulse, read data, error flag
//   *_C2                arbiter client-2 port
//   BUSY                state is not IDLE
//   TXN_COUNT           completed non-error transactions (wrapping)
module c2_requester
  import c2_pkg::*;
#(
  parameter int unsigned ADDR_W         = C2_ADDR_W,
  parameter int unsigned DATA_W         = C2_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              RST_DONE,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_RD_NOT_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WRDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDDATA,
  output logic              RSP_ERR,
  output logic              REQUEST_C2,
  output logic              RD_NOT_WRITE_C2,
  output logic [ADDR_W-1:0] ADDR_C2,
  output logic [DATA_W-1:0] DATAIN_C2,
  input  logic [DATA_W-1:0] DATAOUT_C2,
  input  logic              ACK_C2,
  output logic              BUSY,
  output logic [CNT_W-1:0]  TXN_COUNT
);

  c2_state_e         state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              req_q, req_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  txn_q, txn_d;

  logic              to_load_c;
  logic              to_dec_c;
  logic              to_expire_c;

`ifdef C2_TIMEOUT_EN
  c2_timeout_cnt #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (CLOCK),
    .rst      (RST),
    .load_i   (to_load_c),
    .dec_i    (to_dec_c),
    .expire_c (to_expire_c)
  );
`else
  logic unused_timeout_c;
  assign to_expire_c      = 1'b0;
  assign unused_timeout_c = ^{to_load_c, to_dec_c, 32'(TIMEOUT_CYCLES)};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    txn_d       = txn_q;
    to_load_c   = 1'b0;
    to_dec_c    = 1'b0;

    unique case (state_q)
      WAIT_RDY: begin
        if (RST_DONE && !ACK_C2) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          if (!RST_DONE) begin
            // Accepted the same edge the arbiter went into reset: the command
            // cannot be issued, so answer it with an error rather than drop it.
            state_d     = WAIT_RDY;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            rnw_d     = CMD_RD_NOT_WRITE;
            addr_d    = CMD_ADDR;
            wdata_d   = CMD_WRDATA;
            req_d     = 1'b1;
            to_load_c = 1'b1;
            state_d   = REQ;
          end
        end else if (!RST_DONE) begin
          state_d = WAIT_RDY;
        end
      end

      REQ: begin
        to_dec_c = 1'b1;
        if (!RST_DONE) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = WAIT_RDY;
        end else if (ACK_C2) begin
          // ACK beats a timeout expiring in the same cycle.
          if (rnw_q) begin
            rdata_d = DATAOUT_C2;
          end
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + CNT_W'(1);
          state_d     = REL;
        end else if (to_expire_c) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = REL;
        end
      end

      REL: begin
        if (!RST_DONE) begin
          state_d = WAIT_RDY;
        end else if (!ACK_C2) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = WAIT_RDY;
        req_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q     <= WAIT_RDY;
      cmd_ready_q <= 1'b0;
      req_q       <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      req_q       <= req_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      txn_q       <= txn_d;
    end
  end

  assign CMD_READY       = cmd_ready_q;
  assign REQUEST_C2      = req_q;
  assign RD_NOT_WRITE_C2 = rnw_q;
  assign ADDR_C2         = addr_q;
  assign DATAIN_C2       = wdata_q;
  assign RSP_VALID       = rsp_valid_q;
  assign RSP_ERR         = rsp_err_q;
  assign RSP_RDDATA      = rdata_q;
  assign BUSY            = busy_q;
  assign TXN_COUNT       = txn_q;

endmodule : c2_requester

// File: tb/tb_c2_requester.sv
// tb_c2_requester: directed bench for c2_requester. The arbiter side
// (ACK_C2/DATAOUT_C2) is driven by hand; expected values are hand-computed.
module tb_c2_requester;
  import c2_pkg::*;

  localparam int unsigned ADDR_W = C2_ADDR_W;
  localparam int unsigned DATA_W = C2_DATA_W;
  localparam int unsigned TO_CYC = 8;
  localparam int unsigned CNT_W  = 16;

  logic              CLOCK = 1'b0;
  logic              RST;
  logic              RST_DONE;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_RD_NOT_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WRDATA;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDDATA;
  logic              RSP_ERR;
  logic              REQUEST_C2;
  logic              RD_NOT_WRITE_C2;
  logic [ADDR_W-1:0] ADDR_C2;
  logic [DATA_W-1:0] DATAIN_C2;
  logic [DATA_W-1:0] DATAOUT_C2;
  logic              ACK_C2;
  logic              BUSY;
  logic [CNT_W-1:0]  TXN_COUNT;

  int total = 0;
  int bad   = 0;

  c2_requester #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (CNT_W)
  ) dut (
    .CLOCK            (CLOCK),
    .RST              (RST),
    .RST_DONE         (RST_DONE),
    .CMD_VALID        (CMD_VALID),
    .CMD_READY        (CMD_READY),
    .CMD_RD_NOT_WRITE (CMD_RD_NOT_WRITE),
    .CMD_ADDR         (CMD_ADDR),
    .CMD_WRDATA       (CMD_WRDATA),
    .RSP_VALID        (RSP_VALID),
    .RSP_RDDATA       (RSP_RDDATA),
    .RSP_ERR          (RSP_ERR),
    .REQUEST_C2       (REQUEST_C2),
    .RD_NOT_WRITE_C2  (RD_NOT_WRITE_C2),
    .ADDR_C2          (ADDR_C2),
    .DATAIN_C2        (DATAIN_C2),
    .DATAOUT_C2       (DATAOUT_C2),
    .ACK_C2           (ACK_C2),
    .BUSY             (BUSY),
    .TXN_COUNT        (TXN_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_cmd(input logic rnw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    CMD_VALID        = 1'b1;
    CMD_RD_NOT_WRITE = rnw;
    CMD_ADDR         = a;
    CMD_WRDATA       = d;
  endtask

  initial begin
    RST = 1'b1; RST_DONE = 1'b0; CMD_VALID = 1'b0; CMD_RD_NOT_WRITE = 1'b0;
    CMD_ADDR = '0; CMD_WRDATA = '0; DATAOUT_C2 = '0; ACK_C2 = 1'b0;
    step(); step();

    // Reset values
    check("rst_req",   32'(REQUEST_C2), 32'd0);
    check("rst_ready", 32'(CMD_READY),  32'd0);
    check("rst_busy",  32'(BUSY),       32'd0);
    check("rst_rsp",   32'(RSP_VALID),  32'd0);
    check("rst_txn",   32'(TXN_COUNT),  32'd0);

    // Reset released, arbiter not ready, command pending: nothing issued
    RST = 1'b0;
    set_cmd(1'b0, 4'hE, 8'hE3);
    for (int i = 0; i < 10; i++) begin
      step();
      check("nrdy_req",   32'(REQUEST_C2), 32'd0);
      check("nrdy_ready", 32'(CMD_READY),  32'd0);
    end
    check("nrdy_busy", 32'(BUSY), 32'd1);

    // Write 0xE3 to 0xE, ACK 3 cycles after REQUEST
    RST_DONE = 1'b1;
    step();
    check("wr_idle_ready", 32'(CMD_READY),  32'd1);
    check("wr_idle_req",   32'(REQUEST_C2), 32'd0);
    step();
    CMD_VALID = 1'b0;
    check("wr_req",   32'(REQUEST_C2), 32'd1);
    check("wr_ready", 32'(CMD_READY),  32'd0);
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_req",  32'(REQUEST_C2),      32'd1);
      check("wr_hold_addr", 32'(ADDR_C2),         32'hE);
      check("wr_hold_data", 32'(DATAIN_C2),       32'hE3);
      check("wr_hold_rnw",  32'(RD_NOT_WRITE_C2), 32'd0);
      check("wr_hold_rsp",  32'(RSP_VALID),       32'd0);
      step();
    end
    ACK_C2 = 1'b1; DATAOUT_C2 = 8'h55;
    check("wr_ack_addr", 32'(ADDR_C2),   32'hE);
    check("wr_ack_data", 32'(DATAIN_C2), 32'hE3);
    step();
    check("wr_rsp_valid", 32'(RSP_VALID),  32'd1);
    check("wr_rsp_err",   32'(RSP_ERR),    32'd0);
    check("wr_req_fall",  32'(REQUEST_C2), 32'd0);
    check("wr_txn",       32'(TXN_COUNT),  32'd1);
    check("wr_rddata",    32'(RSP_RDDATA), 32'h00);
    step();
    check("wr_rsp_once", 32'(RSP_VALID), 32'd0);
    check("wr_rel_rdy",  32'(CMD_READY), 32'd0);
    ACK_C2 = 1'b0;
    step();
    check("wr_back_idle", 32'(CMD_READY), 32'd1);

    // Read 0xE, arbiter returns 0xE3 with ACK
    set_cmd(1'b1, 4'hE, 8'h00);
    step();
    CMD_VALID = 1'b0;
    check("rd_req", 32'(REQUEST_C2),      32'd1);
    check("rd_rnw", 32'(RD_NOT_WRITE_C2), 32'd1);
    ACK_C2 = 1'b1; DATAOUT_C2 = 8'hE3;
    step();
    check("rd_req_fall", 32'(REQUEST_C2), 32'd0);
    check("rd_valid",    32'(RSP_VALID),  32'd1);
    check("rd_data",     32'(RSP_RDDATA), 32'hE3);
    check("rd_txn",      32'(TXN_COUNT),  32'd2);
    ACK_C2 = 1'b0; DATAOUT_C2 = 8'h00;
    step();
    check("rd_idle", 32'(CMD_READY), 32'd1);

    // Back-to-back with VALID held high, ACK held for 5 cycles
    set_cmd(1'b0, 4'h3, 8'h5A);
    step();
    check("b2b_req1", 32'(REQUEST_C2), 32'd1);
    set_cmd(1'b1, 4'h7, 8'h00);
    ACK_C2 = 1'b1;
    step();
    check("b2b_rsp1", 32'(RSP_VALID), 32'd1);
    check("b2b_txn1", 32'(TXN_COUNT), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_ack_req",   32'(REQUEST_C2), 32'd0);
      check("b2b_ack_ready", 32'(CMD_READY),  32'd0);
    end
    ACK_C2 = 1'b0;
    step();
    check("b2b_noreq", 32'(REQUEST_C2), 32'd0);
    step();
    CMD_VALID = 1'b0;
    check("b2b_req2",  32'(REQUEST_C2),      32'd1);
    check("b2b_addr2", 32'(ADDR_C2),         32'h7);
    check("b2b_rnw2",  32'(RD_NOT_WRITE_C2), 32'd1);
    ACK_C2 = 1'b1; DATAOUT_C2 = 8'h3C;
    step();
    check("b2b_data2", 32'(RSP_RDDATA), 32'h3C);
    check("b2b_txn2",  32'(TXN_COUNT),  32'd4);
    ACK_C2 = 1'b0;
    step();

    // RST_DONE drops in REQ: error response, count unchanged, then recovery
    set_cmd(1'b0, 4'h1, 8'h11);
    step();
    CMD_VALID = 1'b0;
    step();
    check("arst_req_pre", 32'(REQUEST_C2), 32'd1);
    RST_DONE = 1'b0;
    step();
    check("arst_req",   32'(REQUEST_C2), 32'd0);
    check("arst_valid", 32'(RSP_VALID),  32'd1);
    check("arst_err",   32'(RSP_ERR),    32'd1);
    check("arst_txn",   32'(TXN_COUNT),  32'd4);
    step();
    check("arst_once",  32'(RSP_VALID), 32'd0);
    check("arst_ready", 32'(CMD_READY), 32'd0);
    RST_DONE = 1'b1;
    step();
    check("arst_recover", 32'(CMD_READY), 32'd1);
    set_cmd(1'b1, 4'h9, 8'h00);
    step();
    CMD_VALID = 1'b0;
    ACK_C2 = 1'b1; DATAOUT_C2 = 8'h96;
    step();
    check("rec_data", 32'(RSP_RDDATA), 32'h96);
    check("rec_err",  32'(RSP_ERR),    32'd0);
    check("rec_txn",  32'(TXN_COUNT),  32'd5);
    ACK_C2 = 1'b0;
    step();

    // No ACK at all
    set_cmd(1'b0, 4'h2, 8'h22);
    step();
    CMD_VALID = 1'b0;
    check("to_req", 32'(REQUEST_C2), 32'd1);
`ifdef C2_TIMEOUT_EN
    for (int i = 1; i < int'(TO_CYC); i++) begin
      step();
      check("to_wait_req", 32'(REQUEST_C2), 32'd1);
      check("to_wait_rsp", 32'(RSP_VALID),  32'd0);
    end
    step();
    check("to_valid", 32'(RSP_VALID),  32'd1);
    check("to_err",   32'(RSP_ERR),    32'd1);
    check("to_req0",  32'(REQUEST_C2), 32'd0);
    check("to_txn",   32'(TXN_COUNT),  32'd5);
    step();
    check("to_idle", 32'(CMD_READY), 32'd1);
    set_cmd(1'b0, 4'h4, 8'h44);
    step();
    CMD_VALID = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("nto_req", 32'(REQUEST_C2), 32'd1);
      check("nto_rsp", 32'(RSP_VALID),  32'd0);
    end
`endif

    // Local reset mid-request: straight back to reset values, no response
    RST = 1'b1;
    step();
    check("mrst_req",   32'(REQUEST_C2), 32'd0);
    check("mrst_rsp",   32'(RSP_VALID),  32'd0);
    check("mrst_txn",   32'(TXN_COUNT),  32'd0);
    check("mrst_addr",  32'(ADDR_C2),    32'd0);
    check("mrst_ready", 32'(CMD_READY),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_c2_requester
